// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_param
// Description : Parametrised sequential shift-add multiplier. Operands are
//               converted to magnitudes at start, one partial product is
//               accumulated per clock, and the sign is restored when the
//               result is registered. Start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_param #(
    parameter int W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     signed_mode,
    input  logic [W-1:0]             A,
    input  logic [W-1:0]             B,
    output logic                     busy,
    output logic                     done,
    output logic [2*W-1:0]           product,
    output logic [$clog2(W+1)-1:0]   counter
);

    localparam int CW = $clog2(W+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;

    // Operand magnitude, sign of the result and the split accumulator.
    // acc_hi carries one extra bit so the add never loses its carry before
    // the shift brings it back down.
    logic [W-1:0]    a_mag;
    logic            neg;
    logic [W:0]      acc_hi;
    logic [W-1:0]    acc_lo;

    logic [W-1:0]    a_in_mag;
    logic [W-1:0]    b_in_mag;
    logic            in_neg;
    logic [W:0]      step_sum;
    logic [W:0]      step_hi;
    logic [W-1:0]    step_lo;
    logic [2*W-1:0]  raw_prod;
    logic [2*W-1:0]  final_prod;

    // Magnitude of an operand; in signed mode the most negative value maps
    // to 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x,
                                               input logic         sm);
        if (sm && x[W-1]) begin
            return ~x + W'(1);
        end
        return x;
    endfunction

    // Input-side magnitudes and result sign, captured on an accepted start.
    always_comb begin
        a_in_mag = magnitude(A, signed_mode);
        b_in_mag = magnitude(B, signed_mode);
        in_neg   = signed_mode & (A[W-1] ^ B[W-1]);
    end

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift the whole accumulator right by one.
    always_comb begin
        step_sum = acc_hi + ({1'b0, a_mag} & {(W+1){acc_lo[0]}});
        step_hi  = {1'b0, step_sum[W:1]};
        step_lo  = {step_sum[0], acc_lo[W-1:1]};
    end

    // Final result: the low 2W accumulator bits, negated when the operand
    // signs differed.
    always_comb begin
        raw_prod   = {acc_hi[W-1:0], acc_lo};
        final_prod = neg ? (~raw_prod + (2*W)'(1)) : raw_prod;
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            counter <= '0;
            a_mag   <= '0;
            neg     <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_mag   <= a_in_mag;
                        neg     <= in_neg;
                        acc_hi  <= '0;
                        acc_lo  <= b_in_mag;
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (counter == CW'(W)) begin
                        // All W partial products are in; publish the result.
                        product <= final_prod;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        acc_hi  <= step_hi;
                        acc_lo  <= step_lo;
                        counter <= counter + CW'(1);
                    end
                end
                DONE: begin
                    // Start is deliberately not sampled here; it is only
                    // honoured once back in IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_param
// Description : Self-checking bench for seq_mult_param at W=4 and W=8 with a
//               plain-arithmetic reference product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start4 = 1'b0, sm4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4;
    logic [7:0] prod4;
    logic [2:0] cnt4;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic [3:0]  cnt8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .product(prod4), .counter(cnt4)
    );

    seq_mult_param #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .product(prod8), .counter(cnt8)
    );

    // Reference: interpret operands as integers, multiply, keep 2W bits.
    function automatic longint model(input int w, input logic [7:0] a,
                                     input logic [7:0] b, input logic sm);
        longint ai = longint'(a);
        longint bi = longint'(b);
        if (sm && a[w-1]) ai -= (longint'(1) << w);
        if (sm && b[w-1]) bi -= (longint'(1) << w);
        return (ai * bi) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Runs one W=4 operation from an idle negedge; scrambles inputs while busy.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        output logic [7:0] p, output int lat, output int bcnt,
                        output int dcnt, output logic [2:0] c);
        p = '0; lat = -1; bcnt = 0; dcnt = 0; c = '0;
        a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (busy4) bcnt++;
            if (done4) begin dcnt++; lat = k - 1; p = prod4; c = cnt4; end
            if (!busy4 && dcnt > 0) break;
            a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output logic [15:0] p, output int lat, output int bcnt,
                        output int dcnt, output logic [3:0] c);
        p = '0; lat = -1; bcnt = 0; dcnt = 0; c = '0;
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (busy8) bcnt++;
            if (done8) begin dcnt++; lat = k - 1; p = prod8; c = cnt8; end
            if (!busy8 && dcnt > 0) break;
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy4, done4, prod4, cnt4} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_w4: got busy=%b done=%b prod=%h cnt=%0d, want all zero",
                     busy4, done4, prod4, cnt4);
        end
        vectors++;
        if ({busy8, done8, prod8, cnt8} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_w8: got busy=%b done=%b prod=%h cnt=%0d, want all zero",
                     busy8, done8, prod8, cnt8);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        logic [3:0] av [6] = '{4'd13, 4'd15, 4'd0, 4'd1, 4'd9, 4'd6};
        logic [3:0] bv [6] = '{4'd11, 4'd15, 4'd9, 4'd0, 4'd14, 4'd7};
        logic [7:0] p, e;
        logic [2:0] c;
        int lat, bcnt, dcnt;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] a = (i < 6) ? av[i] : 4'($urandom);
            logic [3:0] b = (i < 6) ? bv[i] : 4'($urandom);
            run4(a, b, 1'b0, p, lat, bcnt, dcnt, c);
            e = 8'(model(4, {4'd0, a}, {4'd0, b}, 1'b0));
            vectors++;
            if (p !== e) begin
                miscompares++;
                $display("FAIL unsigned_prod %0d*%0d: got %0d want %0d", a, b, p, e);
            end
            vectors++;
            if (lat != 5 || bcnt != 6 || dcnt != 1 || c !== 3'd4) begin
                miscompares++;
                $display("FAIL unsigned_timing: got lat=%0d busy=%0d dones=%0d cnt=%0d want 5/6/1/4",
                         lat, bcnt, dcnt, c);
            end
        end
    endtask

    task automatic test_signed;
        logic [3:0] av [5] = '{4'b1000, 4'b1101, 4'd7, 4'b1000, 4'b1000};
        logic [3:0] bv [5] = '{4'b1000, 4'd5, 4'b1111, 4'd7, 4'b0000};
        logic [7:0] p, e;
        logic [2:0] c;
        int lat, bcnt, dcnt;
        for (int i = 0; i < 12; i++) begin
            logic [3:0] a = (i < 5) ? av[i] : 4'($urandom);
            logic [3:0] b = (i < 5) ? bv[i] : 4'($urandom);
            run4(a, b, 1'b1, p, lat, bcnt, dcnt, c);
            e = 8'(model(4, {4'd0, a}, {4'd0, b}, 1'b1));
            vectors++;
            if (p !== e) begin
                miscompares++;
                $display("FAIL signed_prod %h*%h: got %h want %h", a, b, p, e);
            end
            vectors++;
            if (lat != 5 || dcnt != 1 || c !== 3'd4) begin
                miscompares++;
                $display("FAIL signed_timing: got lat=%0d dones=%0d cnt=%0d want 5/1/4", lat, dcnt, c);
            end
        end
    endtask

    task automatic test_handshake;
        logic [7:0] p, prev;
        logic [2:0] c;
        int lat, bcnt, dcnt;
        logic unstable = 1'b0;
        run4(4'd9, 4'd7, 1'b0, prev, lat, bcnt, dcnt, c);
        a4 = 4'd3; b4 = 4'd4; sm4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        dcnt = 0; p = '0;
        for (int k = 1; k <= 20; k++) begin
            if (dcnt == 0 && !done4 && prod4 !== prev) unstable = 1'b1;
            if (done4) begin dcnt++; p = prod4; end
            // Intrusive starts: one mid-calculation, one in the done cycle.
            start4 = (k == 2) || done4;
            a4 = 4'd15; b4 = 4'd15;
            @(negedge clk);
        end
        start4 = 1'b0;
        vectors++;
        if (dcnt != 1 || p !== 8'd12) begin
            miscompares++;
            $display("FAIL ignore_start: got dones=%0d prod=%0d want 1/12", dcnt, p);
        end
        vectors++;
        if (unstable) begin
            miscompares++;
            $display("FAIL product_hold: got product changing mid-op, want %0d held", prev);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] av [3];
        logic [3:0] bv [3];
        logic [7:0] got [3];
        int n = 0;
        for (int i = 0; i < 3; i++) begin av[i] = 4'($urandom); bv[i] = 4'($urandom); end
        a4 = av[0]; b4 = bv[0]; sm4 = 1'b0; start4 = 1'b1;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (done4) begin
                got[n] = prod4;
                n++;
                if (n < 3) begin a4 = av[n]; b4 = bv[n]; end
            end
        end
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results want 3", n);
        end
        for (int i = 0; i < n; i++) begin
            logic [7:0] e = 8'(model(4, {4'd0, av[i]}, {4'd0, bv[i]}, 1'b0));
            vectors++;
            if (got[i] !== e) begin
                miscompares++;
                $display("FAIL b2b_prod[%0d]: got %0d want %0d", i, got[i], e);
            end
        end
    endtask

    task automatic test_reset_midop;
        logic [7:0] p;
        logic [2:0] c;
        int lat, bcnt, dcnt;
        logic reached = 1'b0;
        a4 = 4'd9; b4 = 4'd7; sm4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 10 && !reached; k++) begin
            if (cnt4 == 3'd2) reached = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL midop_reach: got cnt=%0d want 2", cnt4);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy4, done4, prod4, cnt4} !== 13'd0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b prod=%h cnt=%0d want zeros",
                     busy4, done4, prod4, cnt4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run4(4'd5, 4'd6, 1'b0, p, lat, bcnt, dcnt, c);
        vectors++;
        if (p !== 8'd30 || lat != 5 || dcnt != 1) begin
            miscompares++;
            $display("FAIL post_reset: got prod=%0d lat=%0d dones=%0d want 30/5/1", p, lat, dcnt);
        end
    endtask

    task automatic test_w8_random;
        logic [15:0] p, e;
        logic [3:0] c;
        int lat, bcnt, dcnt;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a = 8'($urandom);
            logic [7:0] b = 8'($urandom);
            logic sm = 1'($urandom);
            if (i == 0) begin a = 8'h80; b = 8'h80; sm = 1'b1; end
            if (i == 1) begin a = 8'hFF; b = 8'hFF; sm = 1'b0; end
            run8(a, b, sm, p, lat, bcnt, dcnt, c);
            e = 16'(model(8, a, b, sm));
            vectors++;
            if (p !== e) begin
                miscompares++;
                $display("FAIL w8_prod %h*%h sm=%b: got %h want %h", a, b, sm, p, e);
            end
            vectors++;
            if (lat != 9 || bcnt != 10 || dcnt != 1 || c !== 4'd8) begin
                miscompares++;
                $display("FAIL w8_timing: got lat=%0d busy=%0d dones=%0d cnt=%0d want 9/10/1/8",
                         lat, bcnt, dcnt, c);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_handshake();
        test_back_to_back();
        test_reset_midop();
        test_w8_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
